// File: rtl/demux1x8_reg.sv
// Registered 1-to-8 demultiplexer.
// Each destination is an independent register slice; the slice whose index
// matches {x2,x1,x0} captures `in` and every other slice clears, so after an
// enabled edge at most one output is nonzero. All outputs come straight from
// flops, giving one cycle of latency and glitch-free destinations.

module demux1x8_lane #(
    parameter int               DATA_W    = 1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter logic [2:0]        LANE_SEL  = 3'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [2:0]        sel,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] q
);

    // Capture data when this lane is selected, clear otherwise; hold when disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= RESET_VAL;
        else if (en)
            q <= (sel == LANE_SEL) ? in : '0;
    end

endmodule

module demux1x8_reg #(
    parameter int                DATA_W    = 1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              x0,
    input  logic              x1,
    input  logic              x2,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] e,
    output logic [DATA_W-1:0] f,
    output logic [DATA_W-1:0] g,
    output logic [DATA_W-1:0] h
);

    localparam int NUM_LANES = 8;

    logic [2:0]                        sel;
    logic [NUM_LANES-1:0][DATA_W-1:0]  lane_q;

    assign sel = {x2, x1, x0};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        demux1x8_lane #(
            .DATA_W   (DATA_W),
            .RESET_VAL(RESET_VAL),
            .LANE_SEL (3'(i))
        ) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (en),
            .sel  (sel),
            .in   (in),
            .q    (lane_q[i])
        );
    end

    assign a = lane_q[0];
    assign b = lane_q[1];
    assign c = lane_q[2];
    assign d = lane_q[3];
    assign e = lane_q[4];
    assign f = lane_q[5];
    assign g = lane_q[6];
    assign h = lane_q[7];

endmodule

// File: tb/tb_demux1x8_reg.sv
// Bench for demux1x8_reg: a 1-bit and a 4-bit instance share clock, reset,
// enable and select. Table vectors, hand sequences for reset/enable corners,
// counter-pattern and random stimulus against an array-based reference model.

module tb_demux1x8_reg;

    logic clk, rst_n, en, x0, x1, x2;
    logic in1;
    logic a1, b1, c1, d1, e1, f1, g1, h1;
    logic [3:0] in4;
    logic [3:0] a4, b4, c4, d4, e4, f4, g4, h4;

    logic [7:0]      o1;
    logic [7:0][3:0] o4;
    assign o1 = {h1, g1, f1, e1, d1, c1, b1, a1};
    assign o4 = {h4, g4, f4, e4, d4, c4, b4, a4};

    // reference model: what each destination should hold
    logic [7:0]      m1;
    logic [7:0][3:0] m4;

    int n_chk = 0;
    int n_fail = 0;

    demux1x8_reg #(.DATA_W(1), .RESET_VAL(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .x0(x0), .x1(x1), .x2(x2), .in(in1),
        .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1), .h(h1)
    );

    demux1x8_reg #(.DATA_W(4), .RESET_VAL(4'h0)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .x0(x0), .x1(x1), .x2(x2), .in(in4),
        .a(a4), .b(b4), .c(c4), .d(d4), .e(e4), .f(f4), .g(g4), .h(h4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [2:0] sel;
        logic       in;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // drive inputs, take one rising edge, advance the model, settle 1ns past the edge
    task automatic step(input logic en_v, input logic [2:0] s, input logic i1, input logic [3:0] i4);
        en = en_v;
        {x2, x1, x0} = s;
        in1 = i1;
        in4 = i4;
        @(posedge clk);
        if (rst_n && en_v) begin
            m1 = '0;
            m1[s] = i1;
            m4 = '0;
            m4[s] = i4;
        end
        #1;
    endtask

    initial begin
        logic [7:0]      exp1;
        logic [7:0][3:0] exp4;
        logic [4:0]      tv;
        logic [2:0]      rs;
        logic            ri, re;

        // stimulus table: sweep with in=1, sweep with in=0, enable hold
        for (int i = 0; i < 8; i++) tbl.push_back('{1'b1, 3'(i), 1'b1, 8'(1 << i)});
        for (int i = 0; i < 8; i++) tbl.push_back('{1'b1, 3'(i), 1'b0, 8'h00});
        tbl.push_back('{1'b1, 3'd3, 1'b1, 8'h08});
        for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 3'd6, 1'b0, 8'h08});
        tbl.push_back('{1'b1, 3'd6, 1'b0, 8'h00});

        // reset held with active-looking inputs and clock running
        rst_n = 1'b0; en = 1'b1; {x2, x1, x0} = 3'b101; in1 = 1'b1; in4 = 4'hF;
        m1 = '0; m4 = '0;
        #1;
        chk("reset_t0_w1", 32'(o1), 32'h0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("reset_hold_w1", 32'(o1), 32'h0);
            chk("reset_hold_w4", 32'(o4), 32'h0);
        end

        // deassert between edges; first update on the next edge
        rst_n = 1'b1;
        step(1'b1, 3'd5, 1'b1, 4'hF);
        chk("first_update_w1", 32'(o1), 32'h20);
        chk("first_update_w4", 32'(o4), 32'h00F0_0000);

        // asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_w1", 32'(o1), 32'h0);
        chk("async_reset_w4", 32'(o4), 32'h0);
        m1 = '0; m4 = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // table-driven vectors
        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].en, tbl[k].sel, tbl[k].in, {4{tbl[k].in}});
            chk($sformatf("tbl[%0d]", k), 32'(o1), 32'(tbl[k].exp));
        end

        // width check on the 4-bit instance
        step(1'b1, 3'd2, 1'b1, 4'hA);
        exp4 = '0;
        exp4[2] = 4'hA;
        chk("width_sel2_A", 32'(o4), 32'(exp4));

        // counter pattern: x0 every cycle, x1 every 2, x2 every 4, in every 8
        for (int t = 0; t < 32; t++) begin
            tv = 5'(t);
            step(1'b1, tv[2:0], tv[3], 4'(t * 3 + 1));
            exp1 = '0;
            exp1[tv[2:0]] = tv[3];
            chk("counter_w1", 32'(o1), 32'(exp1));
            chk("counter_or", 32'(|o1), 32'(tv[3]));
            chk("counter_w4", 32'(o4), 32'(m4));
        end

        // random stimulus against the model
        for (int t = 0; t < 300; t++) begin
            re = ($urandom_range(0, 3) != 0);
            rs = 3'($urandom_range(0, 7));
            ri = 1'($urandom_range(0, 1));
            step(re, rs, ri, 4'($urandom_range(0, 15)));
            chk("rand_w1", 32'(o1), 32'(m1));
            chk("rand_w4", 32'(o4), 32'(m4));
            if (re) chk("rand_or", 32'(|o1), 32'(ri));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/demux1x8_reg.md
Name: demux1x8_reg

Overview:
Registered 1-to-8 demultiplexer. Routes the input bit `in` to one of eight outputs `a`..`h`, chosen by the 3-bit select {x2,x1,x0}. All outputs register on the rising clock edge, so there is one cycle of latency. Used wherever a single serial/strobe line must be steered to one of eight destinations with glitch-free registered outputs.

Parameters:
- DATA_W, 1, width of `in` and of each output `a`..`h`. The 1x8 use case is DATA_W=1.
- RESET_VAL, 0, value loaded into every output on reset; DATA_W bits wide.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  update enable; outputs hold their value when low
- x0  input  1  select bit 0 (LSB)
- x1  input  1  select bit 1
- x2  input  1  select bit 2 (MSB)
- in  input  DATA_W  data to route
- a  output  DATA_W  destination 0 (sel=000)
- b  output  DATA_W  destination 1 (sel=001)
- c  output  DATA_W  destination 2 (sel=010)
- d  output  DATA_W  destination 3 (sel=011)
- e  output  DATA_W  destination 4 (sel=100)
- f  output  DATA_W  destination 5 (sel=101)
- g  output  DATA_W  destination 6 (sel=110)
- h  output  DATA_W  destination 7 (sel=111)

Behaviour:
- Select encoding: sel = {x2,x1,x0}, unsigned 0..7. Mapping is 0->a, 1->b, 2->c, 3->d, 4->e, 5->f, 6->g, 7->h.
- Reset:
  - While rst_n=0, all of a..h equal RESET_VAL immediately, independent of clk.
  - Deassertion takes effect at the next rising clk edge; the first update happens on that edge if en=1.
- Each rising clk edge with rst_n=1 and en=1:
  - The selected output takes `in`.
  - All seven non-selected outputs take 0 (all DATA_W bits zero).
- Rising edge with en=0: all outputs hold their previous values.
- Latency: one cycle. Outputs reflect sel and `in` as sampled at the previous rising edge.
- Invariant after any enabled update: at most one output is nonzero. With DATA_W=1, exactly one output equals `in`, so the OR of a..h equals `in`.
- Select change and data change on the same edge are sampled together; the output moves to the new destination in one cycle, and the old destination clears on that same edge.
- No combinational path from inputs to outputs; all outputs come directly from flops.
- X/Z on select is not required to be handled; sel is treated as a 3-bit binary value.

Test Plan:
- Reset: hold rst_n=0 with in=1, sel=101 and clk toggling -> a..h all 0 throughout. Assert rst_n=0 asynchronously mid-cycle after outputs are set -> outputs go to 0 without waiting for a clock edge.
- Exhaustive sweep: en=1, in=1, sel stepping 0..7, one per cycle -> one cycle later exactly one output is 1, in the order a,b,c,d,e,f,g,h; all others are 0.
- Data zero: en=1, in=0, sel counting 0..7 -> all outputs 0 every cycle.
- Counter stimulus: x0 toggles every cycle, x1 every 2, x2 every 4, `in` every 8, over 32 cycles -> the output indexed by the previous-cycle sel equals the previous-cycle `in`; the OR of all outputs equals the previous `in`.
- Enable hold: set sel=011, in=1, en=1 (d=1); then en=0 with sel=110, in=0 for 3 cycles -> d stays 1 and g stays 0. Re-enable -> d=0, g=0 (in=0).
- Width check with DATA_W=4: sel=010, in=4'hA -> c=4'hA, all other outputs 4'h0 one cycle later.
